// File: rtl/mshr_alloc_ctrl_pkg.sv
// Shared types and sizing for the dcache MSHR allocation front end.
package mshr_alloc_ctrl_pkg;

    localparam int MSHR_AW            = 2;
    localparam int DCACHE_TAG_WIDTH   = 20;
    localparam int DCACHE_INDEX_WIDTH = 12;

    typedef enum logic [1:0] {
        II = 2'd0,
        IS = 2'd1,
        IM = 2'd2,
        MI = 2'd3
    } transient_state_t;

    typedef enum logic {
        ALLOC_IDLE  = 1'b0,
        ALLOC_ISSUE = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/mshr_alloc_ctrl_free_enc.sv
// Lowest-index free entry finder over the MSHR occupancy bitmap.
module mshr_free_enc #(
    parameter int NENT  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NENT-1:0]  busy,
    output logic [IDX_W-1:0] free_idx,
    output logic             any_free
);

    // Scan from the top so the last hit is the lowest free index.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mshr_alloc_ctrl.sv
// MSHR miss allocator: allocates entries, drives the MSHR write port, issues bus reads.
// Optional perf counters enabled by defining MSHR_PERF_CNT_EN.
module mshr_alloc_ctrl
    import mshr_alloc_ctrl_pkg::*;
#(
    parameter int ADDR_W     = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH,
    parameter int MSHR_AW    = mshr_alloc_ctrl_pkg::MSHR_AW,
    parameter int PERF_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   miss_valid_i,
    output logic                   miss_ready_o,
    input  logic [ADDR_W-1:0]      miss_adr_i,
    input  logic                   miss_is_write_i,
    output logic [MSHR_AW-1:0]     miss_id_o,
    output logic                   mshr_we_o,
    output logic [ADDR_W-1:0]      mshr_adr_o,
    output logic                   mshr_valid_o,
    output transient_state_t       mshr_ts_o,
    output logic [MSHR_AW-1:0]     mshr_wrptr_o,
    output logic                   bus_req_valid_o,
    input  logic                   bus_req_ready_i,
    output logic [ADDR_W-1:0]      bus_req_adr_o,
    output logic [MSHR_AW-1:0]     bus_req_id_o,
    input  logic                   resp_valid_i,
    output logic                   resp_ready_o,
    input  logic [MSHR_AW-1:0]     resp_id_i,
    output logic                   full_o,
    output logic [MSHR_AW:0]       outstanding_o,
    output logic                   err_o
`ifdef MSHR_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0]  perf_alloc_o,
    output logic [PERF_CNT_W-1:0]  perf_full_stall_o
`endif
);

    localparam int NENT = 2 ** MSHR_AW;

    if (PERF_CNT_W < 1) begin : g_bad_perf_w
        $error("PERF_CNT_W must be at least 1");
    end

    function automatic logic [MSHR_AW:0] popcount(input logic [NENT-1:0] v);
        logic [MSHR_AW:0] c;
        c = '0;
        for (int i = 0; i < NENT; i++) c = c + {{MSHR_AW{1'b0}}, v[i]};
        return c;
    endfunction

    alloc_state_t      state_q, state_nxt;
    logic [NENT-1:0]   bitmap_q, bitmap_nxt;
    logic [MSHR_AW-1:0] free_idx;
    logic              any_free;
    logic              alloc_hs, dealloc_hs, resp_busy, dealloc_ok;

    mshr_free_enc #(.NENT(NENT), .IDX_W(MSHR_AW)) u_free_enc (
        .busy     (bitmap_q),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    assign miss_id_o    = free_idx;
    assign miss_ready_o = (state_q == ALLOC_IDLE) & ~full_o & any_free & ~resp_valid_i;
    assign alloc_hs     = miss_valid_i & miss_ready_o;
    assign resp_ready_o = ~alloc_hs;
    assign dealloc_hs   = resp_valid_i & resp_ready_o;
    assign resp_busy    = bitmap_q[resp_id_i];
    assign dealloc_ok   = dealloc_hs & resp_busy;

    always_comb begin
        bitmap_nxt = bitmap_q;
        if (dealloc_ok) bitmap_nxt[resp_id_i] = 1'b0;
        if (alloc_hs)   bitmap_nxt[free_idx]  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ALLOC_IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ALLOC_IDLE:  if (alloc_hs)        state_nxt = ALLOC_ISSUE;
            ALLOC_ISSUE: if (bus_req_ready_i) state_nxt = ALLOC_IDLE;
            default:                          state_nxt = ALLOC_IDLE;
        endcase
    end

    always_comb begin
        bus_req_valid_o = (state_q == ALLOC_ISSUE);
    end

    // Occupancy, status and the one-cycle MSHR write all update on the handshake edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitmap_q      <= '0;
            full_o        <= 1'b0;
            outstanding_o <= '0;
            err_o         <= 1'b0;
            mshr_we_o     <= 1'b0;
            mshr_valid_o  <= 1'b0;
            mshr_ts_o     <= II;
            mshr_wrptr_o  <= '0;
            mshr_adr_o    <= '0;
            bus_req_adr_o <= '0;
            bus_req_id_o  <= '0;
        end else begin
            bitmap_q      <= bitmap_nxt;
            full_o        <= &bitmap_nxt;
            outstanding_o <= popcount(bitmap_nxt);
            if (dealloc_hs && !resp_busy) err_o <= 1'b1;
            if (alloc_hs) begin
                mshr_we_o     <= 1'b1;
                mshr_valid_o  <= 1'b1;
                mshr_ts_o     <= miss_is_write_i ? IM : IS;
                mshr_wrptr_o  <= free_idx;
                mshr_adr_o    <= miss_adr_i;
                bus_req_adr_o <= miss_adr_i;
                bus_req_id_o  <= free_idx;
            end else if (dealloc_ok) begin
                mshr_we_o    <= 1'b1;
                mshr_valid_o <= 1'b0;
                mshr_ts_o    <= II;
                mshr_wrptr_o <= resp_id_i;
                mshr_adr_o   <= '0;
            end else begin
                mshr_we_o    <= 1'b0;
                mshr_valid_o <= 1'b0;
                mshr_ts_o    <= II;
                mshr_wrptr_o <= '0;
                mshr_adr_o   <= '0;
            end
        end
    end

`ifdef MSHR_PERF_CNT_EN
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_alloc_o      <= '0;
            perf_full_stall_o <= '0;
        end else begin
            if (alloc_hs)               perf_alloc_o      <= sat_inc(perf_alloc_o);
            if (miss_valid_i && full_o) perf_full_stall_o <= sat_inc(perf_full_stall_o);
        end
    end
`endif

endmodule
